// File: rtl/moving_average_param.sv
// moving_average_param: streaming mean of the last 2^win_sel samples over a circular history buffer.
// Zeroed history pads the window until it fills; a window change re-clears the history.
module moving_average_param #(
  parameter int DATA_W   = 10,
  parameter int MAX_LOG2 = 4,
  parameter int SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              strobe_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  win_sel,
  input  logic              round_en,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              full,
  output logic              busy,
  output logic              overrun
);
  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int ACC_W = DATA_W + MAX_LOG2;
  typedef enum logic [2:0] {CLEAR, IDLE, READ, UPDATE, OUT} state_t;
  state_t              r_state, w_next;
  logic                r_s_q;
  logic [DATA_W-1:0]   r_buf [DEPTH];
  logic [DATA_W-1:0]   r_x, r_old;
  logic [ACC_W-1:0]    r_acc;
  logic [MAX_LOG2-1:0] r_wp, r_clr;
  logic [MAX_LOG2:0]   r_fill;
  logic [SEL_W-1:0]    r_k;
  logic                w_edge;
  logic [SEL_W-1:0]    w_sel;
  logic [MAX_LOG2:0]   w_n;
  logic [MAX_LOG2-1:0] w_rd;
  logic [ACC_W-1:0]    w_sum;
  assign w_edge = ena & strobe_in & ~r_s_q;
  assign w_sel  = (win_sel > SEL_W'(MAX_LOG2)) ? SEL_W'(MAX_LOG2) : win_sel;
  assign w_n    = (MAX_LOG2+1)'(1) << r_k;
  // Slot leaving the window; for a full-depth window this is the slot about to be overwritten
  assign w_rd   = r_wp - w_n[MAX_LOG2-1:0];
  assign w_sum  = r_acc + ((round_en && r_k != '0) ? ACC_W'(w_n >> 1) : '0);
  assign busy   = r_state != IDLE;
  assign full   = r_fill == w_n;
  always_comb begin
    w_next = r_state == CLEAR  ? (&r_clr ? IDLE : CLEAR) :
             r_state == IDLE   ? (w_sel != r_k ? CLEAR : w_edge ? READ : IDLE) :
             r_state == READ   ? UPDATE :
             r_state == UPDATE ? OUT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= CLEAR;
    else if (ena) r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q      <= 1'b0;
      r_acc      <= '0;
      r_wp       <= '0;
      r_clr      <= '0;
      r_fill     <= '0;
      r_k        <= '0;
      r_x        <= '0;
      r_old      <= '0;
      data_out   <= '0;
      strobe_out <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_s_q <= strobe_in;
      if (ena) begin
        strobe_out <= r_state == OUT;
        if (w_edge && r_state != IDLE) overrun <= 1'b1;
        if (r_state == CLEAR) begin
          r_clr  <= r_clr + 1'b1;
          r_acc  <= '0;
          r_wp   <= '0;
          r_fill <= '0;
          r_k    <= w_sel;
        end
        if (r_state == IDLE && w_next == READ) r_x <= data_in;
        if (r_state == READ) r_old <= r_buf[w_rd];
        if (r_state == UPDATE) begin
          r_acc  <= r_acc + ACC_W'(r_x) - ACC_W'(r_old);
          r_wp   <= r_wp + 1'b1;
          r_fill <= full ? r_fill : r_fill + 1'b1;
        end
        if (r_state == OUT) data_out <= DATA_W'(w_sum >> r_k);
      end
    end
  end
  always_ff @(posedge clk)
    if (ena && (r_state == CLEAR || r_state == UPDATE))
      r_buf[r_state == CLEAR ? r_clr : r_wp] <= r_state == CLEAR ? '0 : r_x;
endmodule
